// File: rtl/din_debounce_if.sv
// Signal bundle between the input synchronizer and the debounce filter. The
// slave side is the filter and the master side is whoever consumes it.
interface din_debounce_if #(
  parameter int DATA_W = 8,
  parameter int GL_W   = 8
);
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;
  logic              dout_vld;
  logic              busy;
  logic [GL_W-1:0]   glitch_cnt;

  modport slave  (input  din, output dout, dout_vld, busy, glitch_cnt);
  modport master (output din, input  dout, dout_vld, busy, glitch_cnt);
endinterface

// File: rtl/din_debounce.sv
// Whole-word stability filter: dout follows din only after din holds one value
// for STABLE_CYC edges. Aborted qualifications are counted in a saturating counter.
module din_debounce #(
  parameter int DATA_W     = 8,
  parameter int STABLE_CYC = 20,
  parameter int CNT_W      = 5,
  parameter int GL_W       = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  din_debounce_if.slave bus
);
  typedef enum logic {IDLE = 1'b0, COUNT = 1'b1} state_e;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] cand_q, cand_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              vld_q, vld_d;
  logic [GL_W-1:0]   gl_q, gl_d;
  logic [GL_W-1:0]   gl_inc;

  // Saturating increment, shared by both abort paths.
  assign gl_inc = (gl_q == {GL_W{1'b1}}) ? gl_q : gl_q + GL_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    dout_d  = dout_q;
    vld_d   = 1'b0;
    gl_d    = gl_q;
    unique case (state_q)
      IDLE: begin
        if (bus.din != dout_q) begin
          cand_d  = bus.din;
          cnt_d   = ONE;
          state_d = COUNT;
        end
      end
      COUNT: begin
        if (bus.din == dout_q) begin
          state_d = IDLE;
          cnt_d   = '0;
          gl_d    = gl_inc;
        end else if (bus.din != cand_q) begin
          // A third value restarts qualification without passing through IDLE.
          cand_d = bus.din;
          cnt_d  = ONE;
          gl_d   = gl_inc;
        end else if (cnt_q == LAST) begin
          dout_d  = cand_q;
          vld_d   = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cand_q  <= '0;
      dout_q  <= '0;
      vld_q   <= 1'b0;
      gl_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      dout_q  <= dout_d;
      vld_q   <= vld_d;
      gl_q    <= gl_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_vld   = vld_q;
  assign bus.busy       = (state_q == COUNT);
  assign bus.glitch_cnt = gl_q;
endmodule

// File: tb/tb_din_debounce.sv
// Directed bench for din_debounce with STABLE_CYC=4: acceptance latency, glitch
// rejection, restart on a third value, async reset and glitch counter saturation.
module tb_din_debounce;
  localparam int DATA_W = 8;
  localparam int GL_W   = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;
  int   vld_seen;

  din_debounce_if #(.DATA_W(DATA_W), .GL_W(GL_W)) bus ();

  din_debounce #(.DATA_W(DATA_W), .STABLE_CYC(4), .CNT_W(5), .GL_W(GL_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.din = 8'h00;
    #2;
    chk("rst_dout", bus.dout, 8'h00);
    chk("rst_vld", bus.dout_vld, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_gl", bus.glitch_cnt, 8'd0);
    step();
    rst_n = 1'b1;

    // Idle with din equal to dout.
    vld_seen = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.dout_vld) vld_seen++;
    end
    chk("idle_vld_seen", vld_seen, 0);
    chk("idle_dout", bus.dout, 8'h00);
    chk("idle_busy", bus.busy, 1'b0);
    chk("idle_gl", bus.glitch_cnt, 8'd0);

    // Clean acceptance of 0x5A.
    bus.din = 8'h5A;
    step();
    chk("acc_busy_e0", bus.busy, 1'b1);
    chk("acc_dout_e0", bus.dout, 8'h00);
    step();
    step();
    chk("acc_dout_e2", bus.dout, 8'h00);
    chk("acc_vld_e2", bus.dout_vld, 1'b0);
    step();
    chk("acc_dout_e3", bus.dout, 8'h5A);
    chk("acc_vld_e3", bus.dout_vld, 1'b1);
    chk("acc_busy_e3", bus.busy, 1'b0);
    step();
    chk("acc_vld_after", bus.dout_vld, 1'b0);
    chk("acc_gl", bus.glitch_cnt, 8'd0);

    // Two-cycle glitch to 0xFF, back to 0x5A.
    vld_seen = 0;
    bus.din = 8'hFF;
    step(); if (bus.dout_vld) vld_seen++;
    step(); if (bus.dout_vld) vld_seen++;
    bus.din = 8'h5A;
    for (int i = 0; i < 4; i++) begin
      step();
      if (bus.dout_vld) vld_seen++;
    end
    chk("gl1_vld_seen", vld_seen, 0);
    chk("gl1_dout", bus.dout, 8'h5A);
    chk("gl1_busy", bus.busy, 1'b0);
    chk("gl1_gl", bus.glitch_cnt, 8'd1);

    // 0x11 interrupted by 0x22: restart counted from first 0x22 sample.
    bus.din = 8'h11;
    step();
    step();
    bus.din = 8'h22;
    step();
    chk("rs_gl", bus.glitch_cnt, 8'd2);
    chk("rs_busy", bus.busy, 1'b1);
    step();
    step();
    chk("rs_dout_e2", bus.dout, 8'h5A);
    step();
    chk("rs_dout_e3", bus.dout, 8'h22);
    chk("rs_vld_e3", bus.dout_vld, 1'b1);
    chk("rs_gl_end", bus.glitch_cnt, 8'd2);

    // Async reset in the middle of qualifying 0x33 (cnt=2).
    bus.din = 8'h33;
    step();
    step();
    chk("ar_busy_pre", bus.busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_dout", bus.dout, 8'h00);
    chk("ar_vld", bus.dout_vld, 1'b0);
    chk("ar_busy", bus.busy, 1'b0);
    chk("ar_gl", bus.glitch_cnt, 8'd0);
    step();
    rst_n = 1'b1;
    step();
    step();
    step();
    chk("ar_dout_e2", bus.dout, 8'h00);
    chk("ar_busy_e2", bus.busy, 1'b1);
    step();
    chk("ar_dout_e3", bus.dout, 8'h33);
    chk("ar_vld_e3", bus.dout_vld, 1'b1);

    // Return dout to 0x00, then 300 single-cycle glitches.
    bus.din = 8'h00;
    for (int i = 0; i < 4; i++) step();
    chk("sat_pre_dout", bus.dout, 8'h00);
    vld_seen = 0;
    for (int i = 0; i < 300; i++) begin
      bus.din = 8'h01;
      step(); if (bus.dout_vld) vld_seen++;
      bus.din = 8'h00;
      step(); if (bus.dout_vld) vld_seen++;
      if (i == 253) chk("sat_gl_254", bus.glitch_cnt, 8'd254);
    end
    chk("sat_gl", bus.glitch_cnt, 8'd255);
    chk("sat_dout", bus.dout, 8'h00);
    chk("sat_vld_seen", vld_seen, 0);
    chk("sat_busy", bus.busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/din_debounce.md
Name: din_debounce

Overview:
- Stability filter for an 8-bit parallel input bus, placed directly downstream of the team's three-flop input delay/synchronizer stage and fed by its output.
- Updates its registered output only after the input has held one value for STABLE_CYC consecutive clock edges.
- Emits a one-cycle update pulse whenever the output changes.
- Keeps a saturating count of rejected glitches for debug readback.

Parameters:
DATA_W, 8, width of din/dout
STABLE_CYC, 20, consecutive sampling edges a new value must hold before acceptance; legal range 2..2^CNT_W-1
CNT_W, 5, width of internal stability counter; must hold STABLE_CYC-1
GL_W, 8, width of glitch counter

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
din  input  DATA_W  bus from the upstream delay/synchronizer stage, already synchronous to clk
dout  output  DATA_W  debounced value, registered
dout_vld  output  1  registered pulse, high for exactly the one cycle in which dout takes a new value
busy  output  1  high while a candidate value is being qualified (state==COUNT), decoded from state register
glitch_cnt  output  GL_W  saturating count of aborted qualifications, registered

Behaviour:
- Reset (rst_n low, asynchronous, effective mid-operation): state=IDLE, cnt=0, cand=0, dout=0, dout_vld=0, glitch_cnt=0; busy=0. Any qualification in progress is discarded.
- Internal registers: state (IDLE/COUNT), cnt[CNT_W], cand[DATA_W].
- dout_vld defaults to 0 every cycle unless set below.
- IDLE:
  - din==dout: hold, cnt stays 0.
  - din!=dout: cand<=din, cnt<=1, ->COUNT.
- COUNT, priority order evaluated each edge:
  1. din==dout: glitch rejected; ->IDLE, cnt<=0, glitch_cnt+1.
  2. din!=cand (a third value): cand<=din, cnt<=1, stay COUNT, glitch_cnt+1.
  3. cnt==STABLE_CYC-1: dout<=cand, dout_vld<=1, cnt<=0, ->IDLE.
  4. otherwise: cnt<=cnt+1.
- Latency:
  - A new value V sampled on edges e0..e(S-1) (S=STABLE_CYC) appears on dout after edge e(S-1), with dout_vld high in that same cycle.
  - Minimum input-change-to-dout latency is S edges.
- A change back-to-back after acceptance is allowed: if dout_vld is high and din already differs from the new dout, IDLE starts a fresh qualification on the next edge.
- glitch_cnt saturates at 2^GL_W-1 with no wrap; it is only cleared by reset.
- Multi-bit comparison covers the whole word: any bit difference counts as a change. There is no per-bit filtering.
- Out-of-reset: if din is nonzero after reset, the block qualifies din against dout=0 like any other change.

Test Plan (DATA_W=8, STABLE_CYC=4):
- Reset, din=0x00 held for 10 cycles -> dout=0x00, dout_vld never high, busy=0, glitch_cnt=0.
- din steps 0x00->0x5A and holds -> busy high from the 1st edge; after 4th sampling edge dout=0x5A, dout_vld high exactly 1 cycle, busy=0, glitch_cnt=0.
- dout=0x5A; din=0xFF for 2 cycles then back to 0x5A -> dout stays 0x5A, no dout_vld, glitch_cnt=1, busy returns 0.
- din=0x11 for 2 cycles then 0x22 held -> qualification restarts on 0x22; dout=0x22 after 4 edges counted from first 0x22 sample; glitch_cnt increments by 1.
- Assert rst_n low asynchronously mid-qualification (cnt=2, candidate 0x33) -> dout, dout_vld, busy, and glitch_cnt go to 0 immediately without a clock edge; after release, din=0x33 must hold a full 4 edges before acceptance.
- Drive 300 alternating 1-cycle glitches (0x01/0x00 around dout=0x00) -> glitch_cnt saturates at 255, dout remains 0x00.
